ex_issue_ctrl: RTL
==================

// Module: ex_issue_ctrl
// PURPOSE
//   Sequences the EX stage. Accepts one decoded instruction per handshake from decode and classifies it.
//   Drives EX issue/writeback strobes and runs the data-memory req/ack handshake for loads and stores.
//   Resolves branches against the flags and generates the front-end flush. Sits between decode and EX.
// PARAMETERS
//   FLUSH_CYCLES  2   cycles flush is held after a taken branch (>=1)
//   CNT_W         16  width of stall counter
// PORTS
//   clk            in   1   single clock, rising edge
//   rst_n          in   1   asynchronous, active-low reset
//   id_valid       in   1   decode holds a valid instruction
//   id_ready       out  1   controller accepts this cycle (combinational from state/flags_pend)
//   id_1ld         in   2   first-level decode class
//   id_special     in   1   special-encoding bit
//   id_2ld         in   4   second-level decode
//   id_b_cond      in   4   branch condition code
//   id_dest_reg    in   3   destination register index
//   flags          in   4   {N,Z,C,V} from EX flag register
//   ex_issue       out  1   1-cycle pulse: EX executes the latched instruction
//   ex_wr_en       out  1   1-cycle pulse: register-file write
//   ex_wr_reg      out  3   write index, valid with ex_wr_en
//   mem_req        out  1   data-memory request, level
//   mem_we         out  1   1=store, 0=load; valid with mem_req
//   mem_ack        in   1   memory completes request
//   branch_taken   out  1   1-cycle pulse, taken branch
//   flush          out  1   front-end flush, FLUSH_CYCLES cycles
//   halted         out  1   HALT executed; sticky until reset
//   stall_cycles   out  CNT_W  perf counter (see CONFIGURATION)
// BEHAVIOUR
//   Accept = id_valid & id_ready. All outputs registered and asserted in cycle after accept.
//   Reset value of every output is 0; the FSM resets to RUN.
//   Classes:
//     1LD=00 ALU   : ex_issue=1, ex_wr_en=1, ex_wr_reg=dest; sets flags_pend for 1 cycle.
//     1LD=01 MEM   : 2LD[0]=1 store, 0 load.
//     1LD=10 BR    : evaluate id_b_cond on flags at accept.
//     1LD=11 CTRL  : special=1 & 2LD=4'hF is HALT; any other CTRL encoding is a NOP (no outputs).
//   FSM RUN/MEM_WAIT/FLUSH/HALTED.
//   RUN:
//     id_ready=1, except 0 when flags_pend=1 and id_1ld=BR: a branch stalls 1 cycle after an ALU op.
//   MEM:
//     - accept -> mem_req=1, mem_we=store, ex_issue=1 -> MEM_WAIT; id_ready=0.
//     - mem_ack is sampled while mem_req=1, including the first req cycle.
//     - On ack: mem_req=0 next cycle; a load also pulses ex_wr_en with ex_wr_reg=dest; -> RUN.
//     - mem_ack while mem_req=0 is ignored.
//   BR:
//     - taken -> branch_taken pulse, flush high FLUSH_CYCLES cycles, state FLUSH (id_ready=0), then RUN.
//     - not taken -> no outputs, stay RUN.
//   HALT: -> HALTED, halted=1, id_ready=0 until rst_n.
//   Conditions (flags {N,Z,C,V}):
//     0 EQ Z        1 NE !Z       2 CS C        3 CC !C       4 MI N        5 PL !N
//     6 VS V        7 VC !V       8 HI C&!Z     9 LS !C|Z
//     A GE N==V     B LT N!=V     C GT !Z&N==V  D LE Z|N!=V   E AL 1        F NV 0
//   Reset mid-operation: mem_req and flush drop asynchronously; no pulse is replayed after reset.
//   Back-to-back ALU ops: one per cycle, no bubbles.
// CONFIGURATION
//   EX_CTRL_PERF_CNT_EN defined: stall_cycles counts cycles with id_valid=1 & id_ready=0.
//     Saturates at all-ones; reset 0.
//   Undefined: stall_cycles tied to 0, no counter flops. The port exists in both builds.
// STRUCTURE
//   scc_pkg: 1LD class constants (ALU/MEM/BR/CTRL), HALT 2LD code, B_cond codes, flag bit
//     indices, FSM state encoding.
//   Sub-module cond_eval: combinational (b_cond, flags) -> taken; reused by any future branch unit.
// TESTING
//   1 ALU dest=3, then ALU dest=5 on consecutive cycles -> ex_wr_en on 2 consecutive cycles;
//     wr_reg 3 then 5; id_ready stays 1.
//   2 Load dest=2, mem_ack delayed 3 cycles -> mem_req high 4 cycles, mem_we=0, id_ready=0 throughout;
//     ex_wr_en with wr_reg=2 in the cycle after ack.
//   3 Store with mem_ack in the first req cycle -> mem_req high exactly 1 cycle; no ex_wr_en.
//   4 ALU then BR cond=EQ, flags=4'b0100 -> id_ready=0 for 1 cycle; branch_taken pulse;
//     flush high 2 cycles.
//   5 BR cond=GT, flags N=1,V=0 -> not taken, no flush.
//     BR cond=NV -> never taken.
//     HALT -> halted=1, id_ready=0 permanently.
//   6 rst_n low during MEM_WAIT -> mem_req=0 asynchronously.
//     Late mem_ack after reset -> no ex_wr_en.
//     PERF build: stall_cycles = 0 after reset.

Source files
------------

// File: rtl/scc_pkg.sv
// Shared encodings for the EX issue controller: decode classes, branch conditions,
// flag bit positions and FSM states.
package scc_pkg;

    localparam logic [1:0] CLS_ALU  = 2'b00;
    localparam logic [1:0] CLS_MEM  = 2'b01;
    localparam logic [1:0] CLS_BR   = 2'b10;
    localparam logic [1:0] CLS_CTRL = 2'b11;

    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_HALTED   = 2'd3
    } state_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator: (b_cond, {N,Z,C,V}) -> taken.
module cond_eval
    import scc_pkg::*;
(
    input  logic [3:0] b_cond,
    input  logic [3:0] flags,
    output logic       taken
);

    logic n, z, c, v;
    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        taken = 1'b0;
        case (b_cond)
            COND_EQ: taken = z;
            COND_NE: taken = !z;
            COND_CS: taken = c;
            COND_CC: taken = !c;
            COND_MI: taken = n;
            COND_PL: taken = !n;
            COND_VS: taken = v;
            COND_VC: taken = !v;
            COND_HI: taken = c && !z;
            COND_LS: taken = !c || z;
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = !z && (n == v);
            COND_LE: taken = z || (n != v);
            COND_AL: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_issue_ctrl.sv
// EX-stage issue controller: accepts decoded instructions, drives EX strobes, memory
// handshake, branch flush and halt. Define EX_CTRL_PERF_CNT_EN to build the stall counter.
module ex_issue_ctrl
    import scc_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [1:0]       id_1ld,
    input  logic             id_special,
    input  logic [3:0]       id_2ld,
    input  logic [3:0]       id_b_cond,
    input  logic [2:0]       id_dest_reg,
    input  logic [3:0]       flags,
    output logic             ex_issue,
    output logic             ex_wr_en,
    output logic [2:0]       ex_wr_reg,
    output logic             mem_req,
    output logic             mem_we,
    input  logic             mem_ack,
    output logic             branch_taken,
    output logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_t          state;
    logic            flags_pend;
    logic [FC_W-1:0] flush_cnt;
    logic [2:0]      mem_dest;
    logic            accept;
    logic            cond_taken;

    // A branch must see flags written by the ALU op just issued, so it waits one cycle.
    assign id_ready = (state == ST_RUN) && !(flags_pend && (id_1ld == CLS_BR));
    assign accept   = id_valid && id_ready;

    cond_eval u_cond_eval (
        .b_cond (id_b_cond),
        .flags  (flags),
        .taken  (cond_taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RUN;
            flags_pend   <= 1'b0;
            flush_cnt    <= '0;
            mem_dest     <= '0;
            ex_issue     <= 1'b0;
            ex_wr_en     <= 1'b0;
            ex_wr_reg    <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            branch_taken <= 1'b0;
            flush        <= 1'b0;
            halted       <= 1'b0;
        end else begin
            ex_issue     <= 1'b0;
            ex_wr_en     <= 1'b0;
            branch_taken <= 1'b0;
            flags_pend   <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (accept) begin
                        case (id_1ld)
                            CLS_ALU: begin
                                ex_issue   <= 1'b1;
                                ex_wr_en   <= 1'b1;
                                ex_wr_reg  <= id_dest_reg;
                                flags_pend <= 1'b1;
                            end
                            CLS_MEM: begin
                                ex_issue <= 1'b1;
                                mem_req  <= 1'b1;
                                mem_we   <= id_2ld[0];
                                mem_dest <= id_dest_reg;
                                state    <= ST_MEM_WAIT;
                            end
                            CLS_BR: begin
                                if (cond_taken) begin
                                    branch_taken <= 1'b1;
                                    flush        <= 1'b1;
                                    flush_cnt    <= FC_W'(FLUSH_CYCLES - 1);
                                    state        <= ST_FLUSH;
                                end
                            end
                            default: begin
                                if (id_special && (id_2ld == OP_HALT)) begin
                                    halted <= 1'b1;
                                    state  <= ST_HALTED;
                                end
                            end
                        endcase
                    end
                end
                ST_MEM_WAIT: begin
                    // mem_req is always high here, so any ack completes the request.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (!mem_we) begin
                            ex_wr_en  <= 1'b1;
                            ex_wr_reg <= mem_dest;
                        end
                        state <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == '0) begin
                        flush <= 1'b0;
                        state <= ST_RUN;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_RUN;
            endcase
        end
    end

`ifdef EX_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (id_valid && !id_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule
